// File: rtl/conv_pkg.sv
// Shared widths and helpers for the 3x3 convolution MAC pipeline.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH  = 8;
  localparam int NTAPS          = 9;

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // LSB position of tap k in a row-major packed 3x3 vector.
  function automatic int pix_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/conv33_adder_tree.sv
// Nine-term signed adder with a registered, enable-held output.
module conv33_adder_tree
  import conv_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [NTAPS*IN_W-1:0]   terms,
  output logic signed [IN_W+3:0]  sum_q
);

  logic signed [IN_W+3:0] sum_d;

  // Four guard bits cover the growth of nine full-scale terms.
  always_comb begin
    sum_d = sum_q;
    if (en) begin
      sum_d = '0;
      for (int k = 0; k < NTAPS; k++) begin
        sum_d = sum_d + (IN_W+4)'($signed(terms[pix_lsb(k, IN_W) +: IN_W]));
      end
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

endmodule

// File: rtl/conv33_mac_pipe.sv
// 3x3 convolution MAC: products, adder tree, channel accumulator, then
// shift / ReLU / saturation into a stallable output register.
module conv33_mac_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int SHIFT      = 0,
  parameter int RELU_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NTAPS*DATA_WIDTH-1:0]   in_data,
  input  logic [NTAPS*DATA_WIDTH-1:0]   in_weight,
  input  logic                          in_last,
  input  logic signed [ACC_WIDTH-1:0]   bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   result,
  output logic                          sat_flag
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + 4;

  logic adv;

  logic                          vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic signed [ACC_WIDTH-1:0]   bias_p1_q, bias_p1_d;
  logic [NTAPS*PROD_W-1:0]       prod_p1_q, prod_p1_d;

  logic                          vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic signed [ACC_WIDTH-1:0]   bias_p2_q, bias_p2_d;
  logic signed [SUM_W-1:0]       sum_p2_q;

  logic                          vld_p3_q, vld_p3_d;
  logic signed [ACC_WIDTH-1:0]   total_p3_q, total_p3_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, acc_sum;

  logic                          out_valid_q, out_valid_d, sat_q, sat_d;
  logic signed [OUT_WIDTH-1:0]   result_q, result_d;

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [DATA_WIDTH-1:0] a,
                                                   input logic signed [DATA_WIDTH-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  // Returns {clipped, value}; the ReLU clamp alone never reports clipping.
  function automatic logic [OUT_WIDTH:0] shift_relu_sat(input logic signed [ACC_WIDTH-1:0] t);
    logic signed [ACC_WIDTH-1:0] v;
    longint vx;
    v = t >>> SHIFT;
    if (RELU_EN != 0 && v < 0) v = '0;
    vx = longint'(v);
    if (vx > sat_hi(OUT_WIDTH)) return {1'b1, OUT_WIDTH'(sat_hi(OUT_WIDTH))};
    if (vx < sat_lo(OUT_WIDTH)) return {1'b1, OUT_WIDTH'(sat_lo(OUT_WIDTH))};
    return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat_flag  = sat_q;

  conv33_adder_tree #(.IN_W(PROD_W)) u_tree (
    .clk   (clk),
    .en    (adv),
    .terms (prod_p1_q),
    .sum_q (sum_p2_q)
  );

  always_comb begin
    acc_sum     = acc_q + ACC_WIDTH'(sum_p2_q);
    vld_p1_d    = vld_p1_q;
    last_p1_d   = last_p1_q;
    bias_p1_d   = bias_p1_q;
    prod_p1_d   = prod_p1_q;
    vld_p2_d    = vld_p2_q;
    last_p2_d   = last_p2_q;
    bias_p2_d   = bias_p2_q;
    vld_p3_d    = vld_p3_q;
    total_p3_d  = total_p3_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    if (adv) begin
      // stage 1: products
      vld_p1_d  = in_valid;
      last_p1_d = in_last;
      bias_p1_d = bias;
      for (int k = 0; k < NTAPS; k++) begin
        prod_p1_d[pix_lsb(k, PROD_W) +: PROD_W] =
          mul(in_data[pix_lsb(k, DATA_WIDTH) +: DATA_WIDTH],
              in_weight[pix_lsb(k, DATA_WIDTH) +: DATA_WIDTH]);
      end
      // stage 2: adder tree output registered in u_tree
      vld_p2_d  = vld_p1_q;
      last_p2_d = last_p1_q;
      bias_p2_d = bias_p1_q;
      // stage 3: channel accumulation; a last beat drains and clears it
      vld_p3_d = vld_p2_q && last_p2_q;
      if (vld_p2_q) begin
        if (last_p2_q) begin
          total_p3_d = acc_sum + bias_p2_q;
          acc_d      = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
      // stage 4: shift, ReLU, saturate
      out_valid_d = vld_p3_q;
      if (vld_p3_q) {sat_d, result_d} = shift_relu_sat(total_p3_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    last_p1_q  <= last_p1_d;
    bias_p1_q  <= bias_p1_d;
    prod_p1_q  <= prod_p1_d;
    last_p2_q  <= last_p2_d;
    bias_p2_q  <= bias_p2_d;
    total_p3_q <= total_p3_d;
  end

endmodule

// File: tb/tb_conv33_mac_pipe.sv
// Directed bench for conv33_mac_pipe: three parameterisations share one
// stimulus stream and are checked against a queued reference model.
module tb_conv33_mac_pipe;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [9*DW-1:0] in_data = '0;
  logic [9*DW-1:0] in_weight = '0;
  logic signed [AW-1:0] bias = '0;

  logic in_ready_a, in_ready_b, in_ready_c;
  logic ov_a, ov_b, ov_c, sat_a, sat_b, sat_c;
  logic signed [OW-1:0] res_a, res_b, res_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  longint acc_m = 0;
  longint sb[$];
  longint mon_t;
  logic [OW:0] mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  conv33_mac_pipe #(.SHIFT(0), .RELU_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .out_valid(ov_a), .out_ready(out_ready), .result(res_a), .sat_flag(sat_a));

  conv33_mac_pipe #(.SHIFT(0), .RELU_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .out_valid(ov_b), .out_ready(out_ready), .result(res_b), .sat_flag(sat_b));

  conv33_mac_pipe #(.SHIFT(4), .RELU_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .out_valid(ov_c), .out_ready(out_ready), .result(res_c), .sat_flag(sat_c));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OW:0] expect_out(input longint total, input int sh, input bit relu);
    longint v, hi, lo;
    logic [OW-1:0] r;
    v  = total >>> sh;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    if (relu && v < 0) v = 0;
    if (v > hi) begin r = OW'(hi); return {1'b1, r}; end
    if (v < lo) begin r = OW'(lo); return {1'b1, r}; end
    r = OW'(v);
    return {1'b0, r};
  endfunction

  function automatic logic [9*DW-1:0] rep(input int v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
    return {9{b}};
  endfunction

  function automatic logic [9*DW-1:0] one(input int v);
    logic [9*DW-1:0] d;
    d = '0;
    d[DW-1:0] = v[DW-1:0];
    return d;
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic beat(input logic [9*DW-1:0] d, input logic [9*DW-1:0] w,
                      input bit last, input int b);
    longint s;
    bit ok;
    in_data = d; in_weight = w; in_last = last; bias = AW'(b); in_valid = 1'b1;
    s = 0;
    for (int k = 0; k < 9; k++)
      s += longint'($signed(d[k*DW +: DW])) * longint'($signed(w[k*DW +: DW]));
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      #4;
      if (in_ready_a) begin
        ok = 1'b1;
        acc_m += s;
        if (last) begin
          sb.push_back(acc_m + longint'(b));
          acc_m = 0;
        end
      end
      @(negedge clk);
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #4;
    if (rst_n && ov_a && out_ready) begin
      chk("ov_b_matches", ov_b, 1);
      chk("ov_c_matches", ov_c, 1);
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_t = sb.pop_front();
        mon_e = expect_out(mon_t, 0, 1'b1);
        chk("res_relu", res_a, $signed(mon_e[OW-1:0]));
        chk("sat_relu", sat_a, mon_e[OW]);
        mon_e = expect_out(mon_t, 0, 1'b0);
        chk("res_norelu", res_b, $signed(mon_e[OW-1:0]));
        chk("sat_norelu", sat_b, mon_e[OW]);
        mon_e = expect_out(mon_t, 4, 1'b1);
        chk("res_shift4", res_c, $signed(mon_e[OW-1:0]));
        chk("sat_shift4", sat_c, mon_e[OW]);
      end
    end
  end

  initial begin
    logic [9*DW-1:0] w4, rd, rw;
    int c0;
    logic signed [OW-1:0] held;

    repeat (2) @(negedge clk);
    #4;
    chk("rst_out_valid", ov_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_result", res_a, 0);
    chk("rst_sat", sat_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single channel, latency of three edges after acceptance.
    beat(rep(1), rep(2), 1'b1, 0);
    in_valid = 1'b0;
    chk("lat_edge0", ov_a, 0);
    @(negedge clk); chk("lat_edge1", ov_a, 0);
    @(negedge clk); chk("lat_edge2", ov_a, 0);
    @(negedge clk); chk("lat_edge3", ov_a, 1);
    idle(3);

    // Four channels of sum 10 with bias -5.
    w4 = rep(1);
    w4[4*DW +: DW] = 8'd2;
    beat(rep(1), w4, 1'b0, 0);
    beat(rep(1), w4, 1'b0, 0);
    beat(rep(1), w4, 1'b0, 0);
    beat(rep(1), w4, 1'b1, -5);
    idle(6);

    // ReLU / saturation extremes and exact output boundaries.
    beat(rep(-128), rep(127), 1'b1, 0);
    beat(rep(127), rep(127), 1'b1, 0);
    beat(one(127), one(1), 1'b1, 0);
    beat(one(-128), one(1), 1'b1, 0);
    beat(one(-20), one(1), 1'b1, 0);
    idle(6);

    // Back-to-back single-channel pixels at one per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rd[31:0] = $urandom(); rd[63:32] = $urandom(); rd[71:64] = 8'($urandom());
      rw[31:0] = $urandom(); rw[63:32] = $urandom(); rw[71:64] = 8'($urandom());
      beat(rd, rw, 1'b1, int'($urandom_range(0, 200)) - 100);
    end
    chk("throughput_cycles", cyc - c0, 8);
    idle(6);

    // Backpressure: output stalled for five cycles while three pixels stream.
    out_ready = 1'b0;
    beat(one(3), one(1), 1'b1, 0);
    beat(one(5), one(1), 1'b1, 0);
    beat(one(6), one(1), 1'b1, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", in_ready_a, 0);
    chk("stall_out_valid", ov_a, 1);
    held = res_a;
    @(negedge clk);
    chk("stall_result_held", res_a, held);
    chk("stall_in_ready2", in_ready_a, 0);
    out_ready = 1'b1;
    idle(8);

    // Reset in the middle of a four-channel pixel.
    beat(one(4), one(1), 1'b0, 0);
    beat(one(9), one(1), 1'b0, 0);
    idle(3);
    #3 rst_n = 1'b0;
    acc_m = 0;
    #1;
    chk("midrst_out_valid", ov_a, 0);
    chk("midrst_in_ready", in_ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(one(7), one(1), 1'b1, 0);
    idle(8);

    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv33_mac_pipe.md
CONV33_MAC_PIPE -- requirements
Module: conv33_mac_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed width of each window pixel and weight.
REQ-002 Parameter ACC_WIDTH, default 32: signed accumulator and bias width.
REQ-003 Parameter OUT_WIDTH, default 8: signed result width after shift and saturation.
REQ-004 Parameter SHIFT, default 0: arithmetic right shift applied before saturation; allowed range is 0..ACC_WIDTH-1.
REQ-005 Parameter RELU_EN, default 1: 1 means negative values are clamped to 0 before saturation.
REQ-006 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port in_valid, input, 1: one channel beat is present.
REQ-009 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-010 Port in_data, input, 9*DATA_WIDTH: 3x3 window, row-major; pixel k occupies bits [k*DW +: DW].
REQ-011 Port in_weight, input, 9*DATA_WIDTH: 3x3 kernel, same packing as in_data.
REQ-012 Port in_last, input, 1: this beat is the last input channel of the output pixel.
REQ-013 Port bias, input, ACC_WIDTH: signed bias, sampled with the in_last beat.
REQ-014 Port out_valid, output, 1: result holds a valid output pixel.
REQ-015 Port out_ready, input, 1: the downstream consumer accepts result.
REQ-016 Port result, output, OUT_WIDTH: signed output pixel.
REQ-017 Port sat_flag, output, 1: result was clipped; qualified by out_valid.

Function
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-019 The pipeline SHALL advance when adv = !out_valid || out_ready, and in_ready SHALL equal adv.
REQ-020 Stage 1 SHALL register the nine signed 2*DATA_WIDTH products, plus valid, last and bias.
REQ-021 Stage 2 SHALL register the signed 9-term sum at width 2*DATA_WIDTH+4, with no overflow possible.
REQ-022 Stage 3 SHALL sign-extend the sum and add it to the accumulator, which wraps modulo 2^ACC_WIDTH.
- On a non-last beat the result is written back to the accumulator.
- On a last beat, acc+sum+bias goes to the output stage and the accumulator is cleared to 0 in the same cycle.
REQ-023 The output stage SHALL compute v = (acc+sum+bias) >>> SHIFT.
- If RELU_EN=1, v<0 becomes 0.
- v is then saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- sat_flag is 1 when clipping occurred; the ReLU clamp alone does not set it.
REQ-024 Latency SHALL be 3 cycles with no stall: a last beat accepted at edge N gives out_valid=1 after edge N+3.
REQ-025 A single-channel pixel (every beat has in_last=1) SHALL sustain throughput of one pixel per cycle.
REQ-026 While out_valid=1 and out_ready=0, the block SHALL hold result, sat_flag, every pipeline register and the accumulator unchanged.
REQ-027 Bubble stages (valid=0) SHALL NOT modify the accumulator.
REQ-028 out_valid SHALL drop after the handshake unless a new last beat reaches the output stage in the same cycle.
REQ-029 in_ready SHALL be combinational from out_valid and out_ready only, never from in_valid.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously clear all stage valids, the accumulator, out_valid, result and sat_flag to 0.
REQ-031 Reset mid-pixel SHALL discard any partial accumulation; after release, the first accepted beat starts a new pixel.
REQ-032 When rst_n=0, in_ready SHALL read 1; reset deassertion is expected synchronous to clk.

Structure
REQ-033 The shared package conv_pkg SHALL hold the default widths, a function computing the saturation bounds, and the pixel packing index helper.
REQ-034 The 9-input signed adder tree SHALL be a sub-module, conv33_adder_tree, parameterised by input width and registered at its output.
REQ-035 Accumulator, ReLU, shift and saturation logic SHALL live in the top-level module.

Verification
REQ-036 Single channel: all pixels 1, all weights 2, bias 0, SHIFT 0, one last beat -> result 18 after 3 cycles, sat_flag 0.
REQ-037 Four channels: each beat sums to 10 (pixels 1, weights {1,1,1,1,2,1,1,1,1}), bias -5, last on beat 4 -> result 35.
REQ-038 ReLU and saturation:
- Pixels -128, weights 127, RELU_EN=0 -> result -128, sat_flag 1.
- Same stimulus with RELU_EN=1 -> result 0, sat_flag 0.
- Pixels 127, weights 127, SHIFT 4 -> 9072, saturated to 127, sat_flag 1.
REQ-039 Backpressure: out_ready held 0 for 5 cycles while 3 single-channel pixels are streamed -> in_ready falls, no result is lost or duplicated, order is preserved.
REQ-040 Reset after 2 of 4 channels, then a fresh 1-channel pixel of sum 7 with bias 0 -> result 7.
